shift_serial_feeder: RTL and testbench
======================================

# shift_serial_feeder

Upstream feeder for the bidirectional serial shift register: it accepts a parallel word over a valid/ready handshake and emits it one bit per clock on a serial data line. It drives the register's serial input and its left/right select, and holds the select steady for the whole frame. After the data bits it appends a programmable run of zero flush bits, so the word is pushed fully through the downstream register.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥2)
- FLUSH, 4, number of trailing zero bits after the data (≥0; 0 skips flush)

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- din  input  WIDTH  parallel word, sampled only on accept
- dir  input  1  direction, sampled on accept: 1 = shift right (LSB first), 0 = shift left (MSB first)
- valid  input  1  din/dir are valid
- ready  output  1  block is idle and can accept a word
- sout  output  1  serial bit, feeds the register's serial input
- sel  output  1  direction select, feeds the register's select
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse when the frame completes

## Operation
- FSM states: IDLE, DATA, FLUSH, (PAR when SER_PARITY_EN), DONE.
- IDLE: ready=1, busy=0, sout=0, sel holds its last value. Accept occurs when valid && ready at a clock edge; din and dir are latched into a shift/hold register.
- DATA: WIDTH cycles, one bit per cycle.
  - dir=1: din[0] first, through din[WIDTH-1].
  - dir=0: din[WIDTH-1] first, through din[0].
- FLUSH: FLUSH cycles with sout=0. If FLUSH=0, go directly to DONE (or PAR).
- DONE: one cycle with done=1, sout=0, ready=0. Next state is IDLE.
- Bit counter width is $clog2(WIDTH+FLUSH+1) and counts down to zero; no wrap is permitted.
- sel equals the latched dir for the whole frame, including flush and DONE.
- valid while busy is ignored. din/dir changes after accept have no effect.
- Registered outputs only; there is no combinational path from inputs to outputs.

## Timing
- Reset values: sout=0, sel=1, ready=1, busy=0, done=0, FSM=IDLE, counter=0.
- For an accept at edge k:
  - From edge k: sel=dir, busy=1, ready=0, and sout = first data bit.
  - Data occupies cycles k … k+WIDTH−1.
  - Flush occupies k+WIDTH … k+WIDTH+FLUSH−1.
  - done=1 in cycle k+WIDTH+FLUSH.
  - ready=1 again from k+WIDTH+FLUSH+1.
- Frame period is WIDTH+FLUSH+1 cycles. The next accept is possible on the first IDLE cycle, so back-to-back frames have no extra gap.
- Rst asserted in any state (including mid-frame): at the next edge all outputs take reset values and the frame is aborted with no done pulse.
- Rst and valid in the same cycle: Rst wins and nothing is accepted.

## Configuration
- SER_PARITY_EN defined: a PAR state is inserted between DATA and FLUSH.
  - PAR emits one even-parity bit equal to ^din (XOR of the latched word).
  - Frame period becomes WIDTH+FLUSH+2; done shifts one cycle later.
- SER_PARITY_EN undefined: there is no PAR state and no parity logic; timing is as above.

## Test plan
All with WIDTH=8, FLUSH=4.
- Reset: Rst=1 for 2 cycles with valid=1 → sout=0, sel=1, ready=1, busy=0, done=0; no accept.
- din=8'hA5, dir=1 → sout 1,0,1,0,0,1,0,1 then 0,0,0,0; sel=1 throughout; done in the 13th cycle after the accept edge; ready=1 in the 14th.
- din=8'hC3, dir=0 → sout 1,1,0,0,0,0,1,1 then four 0s; sel=0 for the whole frame and held after return to IDLE.
- Hold valid=1 and change din to 8'hFF during an 8'h0F frame → the 8'h0F frame is unaltered; 8'hFF is accepted on the first IDLE cycle and sent with no gap.
- Rst pulse during data bit 3 of an 8'hA5 frame → next cycle shows reset values; no done; ready=1.
- SER_PARITY_EN with din=8'h07, dir=1 → 1,1,1,0,0,0,0,0, parity 1, then four 0s; done in the 14th cycle. With din=8'hA5 the parity bit is 0.

Source files
------------

// File: rtl/shift_serial_feeder_if.sv
// Handshake and serial-line bundle for shift_serial_feeder.
// master = upstream word source, slave = the feeder.
interface shift_serial_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             dir;
  logic             valid;
  logic             ready;
  logic             sout;
  logic             sel;
  logic             busy;
  logic             done;

  modport master (
    output din, dir, valid,
    input  ready, sout, sel, busy, done
  );

  modport slave (
    input  din, dir, valid,
    output ready, sout, sel, busy, done
  );
endinterface

// File: rtl/shift_serial_feeder.sv
// Parallel-to-serial feeder: data bits, optional parity, zero flush.
// Optional parity bit enabled by defining SER_PARITY_EN.
module shift_serial_feeder #(
  parameter int WIDTH = 8,
  parameter int FLUSH = 4
) (
  input  logic Clk,
  input  logic Rst,
  shift_serial_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + FLUSH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_FLSH = 3'd2;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef SER_PARITY_EN
  localparam logic [2:0] S_PAR  = 3'd3;
`endif

  localparam logic [CW-1:0] D_LAST =
    CW'(WIDTH - 1);
  localparam logic [CW-1:0] F_LAST =
    (FLUSH > 0) ? CW'(FLUSH - 1) : '0;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sel_q, sel_d;
  logic             sout_q, sout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [2:0]       tl_state;
  logic [CW-1:0]    tl_cnt;
  logic             tl_done;

  // End of payload: enter flush, or skip straight to DONE.
  always_comb begin
    tl_state = S_DONE;
    tl_cnt   = '0;
    tl_done  = 1'b1;
    if (FLUSH > 0) begin
      tl_state = S_FLSH;
      tl_cnt   = F_LAST;
      tl_done  = 1'b0;
    end
  end

  // Frame sequencing and next serial bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sel_d   = sel_q;
    sout_d  = 1'b0;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.valid && ready_q) begin
          state_d = S_DATA;
          cnt_d   = D_LAST;
          sel_d   = bus.dir;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (bus.dir) begin
            sout_d  = bus.din[0];
            shreg_d = bus.din >> 1;
          end else begin
            sout_d  = bus.din[WIDTH-1];
            shreg_d = bus.din << 1;
          end
`ifdef SER_PARITY_EN
          par_d = ^bus.din;
`endif
        end
      end
      (state_q == S_DATA): begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (sel_q) begin
            sout_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end else begin
            sout_d  = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
          end
        end else begin
`ifdef SER_PARITY_EN
          state_d = S_PAR;
          sout_d  = par_q;
`else
          state_d = tl_state;
          cnt_d   = tl_cnt;
          done_d  = tl_done;
`endif
        end
      end
`ifdef SER_PARITY_EN
      (state_q == S_PAR): begin
        state_d = tl_state;
        cnt_d   = tl_cnt;
        done_d  = tl_done;
      end
`endif
      (state_q == S_FLSH): begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sel_q   <= 1'b1;
      sout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sel_q   <= sel_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.ready = ready_q;
  assign bus.sout  = sout_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_shift_serial_feeder.sv
// Directed bench for shift_serial_feeder (WIDTH=8, FLUSH=4).
// Parity expectations follow SER_PARITY_EN.
module tb_shift_serial_feeder;
  localparam int W = 8;
  localparam int F = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  shift_serial_feeder_if #(.WIDTH(W)) bus ();

  shift_serial_feeder #(.WIDTH(W), .FLUSH(F)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".sout"},  8'(bus.sout),  8'h0);
    chk({tag, ".sel"},   8'(bus.sel),   8'h1);
    chk({tag, ".ready"}, 8'(bus.ready), 8'h1);
    chk({tag, ".busy"},  8'(bus.busy),  8'h0);
    chk({tag, ".done"},  8'(bus.done),  8'h0);
  endtask

  task automatic start(input logic [7:0] d,
                       input logic dr);
    bus.valid = 1'b1;
    bus.din   = d;
    bus.dir   = dr;
    step();
  endtask

  task automatic body(input logic [7:0] d,
                      input logic dr);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = dr ? d[i] : d[W-1-i];
      chk($sformatf("data%0d.sout", i),
          8'(bus.sout), 8'(b));
      chk("data.sel",   8'(bus.sel),   8'(dr));
      chk("data.busy",  8'(bus.busy),  8'h1);
      chk("data.ready", 8'(bus.ready), 8'h0);
      chk("data.done",  8'(bus.done),  8'h0);
      step();
    end
`ifdef SER_PARITY_EN
    chk("par.sout", 8'(bus.sout), 8'(^d));
    chk("par.sel",  8'(bus.sel),  8'(dr));
    step();
`endif
    for (int i = 0; i < F; i++) begin
      chk("flush.sout", 8'(bus.sout), 8'h0);
      chk("flush.sel",  8'(bus.sel),  8'(dr));
      chk("flush.done", 8'(bus.done), 8'h0);
      step();
    end
    chk("done.done",  8'(bus.done),  8'h1);
    chk("done.ready", 8'(bus.ready), 8'h0);
    chk("done.busy",  8'(bus.busy),  8'h1);
    chk("done.sout",  8'(bus.sout),  8'h0);
    chk("done.sel",   8'(bus.sel),   8'(dr));
    step();
    chk("idle.done",  8'(bus.done),  8'h0);
    chk("idle.ready", 8'(bus.ready), 8'h1);
    chk("idle.busy",  8'(bus.busy),  8'h0);
    chk("idle.sout",  8'(bus.sout),  8'h0);
    chk("idle.sel",   8'(bus.sel),   8'(dr));
  endtask

  initial begin
    bus.valid = 1'b1;
    bus.din   = 8'hA5;
    bus.dir   = 1'b0;
    Rst       = 1'b1;
    step();
    chk_reset("rst1");
    step();
    chk_reset("rst2");
    Rst       = 1'b0;
    bus.valid = 1'b0;
    step();
    chk_reset("post_rst");

    start(8'hA5, 1'b1);
    bus.valid = 1'b0;
    body(8'hA5, 1'b1);

    start(8'hC3, 1'b0);
    bus.valid = 1'b0;
    body(8'hC3, 1'b0);
    step();
    chk("c3.sel_held", 8'(bus.sel), 8'h0);

    start(8'h0F, 1'b1);
    bus.din = 8'hFF;
    bus.dir = 1'b1;
    body(8'h0F, 1'b1);
    step();
    bus.valid = 1'b0;
    body(8'hFF, 1'b1);

    start(8'hA5, 1'b0);
    bus.valid = 1'b0;
    step();
    step();
    step();
    chk("abort.bit3", 8'(bus.sout), 8'h0);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk_reset("abort");
    for (int i = 0; i < 15; i++) begin
      chk("abort.no_done", 8'(bus.done), 8'h0);
      chk("abort.ready",   8'(bus.ready), 8'h1);
      step();
    end

    start(8'h07, 1'b1);
    bus.valid = 1'b0;
    body(8'h07, 1'b1);

    start(8'h3C, 1'b0);
    bus.valid = 1'b0;
    body(8'h3C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
